// File: rtl/branch_predictor_gshare_ras.sv
// Fetch-stage next-PC predictor: gshare PHT for conditional branches, direct-mapped BTB and a return-address stack.
// Prediction is combinational from PC; all training state updates on the falling clock edge.
module branch_predictor_gshare_ras #(
  parameter int         XLEN      = 64,
  parameter int         GHR_BITS  = 10,
  parameter int         BTB_IDX   = 8,
  parameter int         RAS_DEPTH = 8,
  parameter logic [1:0] CTR_INIT  = 2'b01
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic [XLEN-1:0] PCPrediction,
  output logic            predTaken,
  output logic [1:0]      predKind,
  input  logic            we,
  input  logic [XLEN-1:0] PCUpdate,
  input  logic [XLEN-1:0] targetUpdate,
  input  logic            takenUpdate,
  input  logic [1:0]      kindUpdate
);

  localparam int PHT_N  = 1 << GHR_BITS;
  localparam int BTB_N  = 1 << BTB_IDX;
  localparam int TAG_W  = XLEN - BTB_IDX - 2;
  localparam int RAS_PW = $clog2(RAS_DEPTH);
  localparam int CNT_W  = $clog2(RAS_DEPTH + 1);

  localparam logic [1:0] KIND_COND   = 2'b00;
  localparam logic [1:0] KIND_JUMP   = 2'b01;
  localparam logic [1:0] KIND_CALL   = 2'b10;
  localparam logic [1:0] KIND_RETURN = 2'b11;

  logic [1:0]          pht_q     [PHT_N];
  logic                btb_vld_q [BTB_N];
  logic [1:0]          btb_kind_q[BTB_N];
  logic [TAG_W-1:0]    btb_tag_q [BTB_N];
  logic [XLEN-1:0]     btb_tgt_q [BTB_N];
  logic [XLEN-1:0]     ras_q     [RAS_DEPTH];

  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [RAS_PW-1:0]   ras_ptr_q, ras_ptr_d;
  logic [CNT_W-1:0]    ras_cnt_q, ras_cnt_d;

  // ---------------- prediction ----------------
  logic [BTB_IDX-1:0]  f_bidx;
  logic [TAG_W-1:0]    f_tag;
  logic [GHR_BITS-1:0] f_pidx;
  logic                f_hit;
  logic [RAS_PW-1:0]   ras_top;

  assign PCPlus4 = PC + XLEN'(4);
  assign f_bidx  = PC[BTB_IDX+1:2];
  assign f_tag   = PC[XLEN-1:BTB_IDX+2];
  assign f_pidx  = PC[GHR_BITS+1:2] ^ ghr_q;
  assign f_hit   = btb_vld_q[f_bidx] && (btb_tag_q[f_bidx] == f_tag);
  // ras_ptr_q addresses the next free slot, so the top lives one below it
  assign ras_top = ras_ptr_q - RAS_PW'(1);

  always_comb begin
    PCPrediction = PCPlus4;
    predTaken    = 1'b0;
    predKind     = KIND_COND;
    if (f_hit) begin
      predKind = btb_kind_q[f_bidx];
      unique case (btb_kind_q[f_bidx])
        KIND_COND: begin
          if (pht_q[f_pidx][1]) begin
            PCPrediction = btb_tgt_q[f_bidx];
            predTaken    = 1'b1;
          end
        end
        KIND_JUMP, KIND_CALL: begin
          PCPrediction = btb_tgt_q[f_bidx];
          predTaken    = 1'b1;
        end
        KIND_RETURN: begin
          PCPrediction = (ras_cnt_q != '0) ? ras_q[ras_top] : btb_tgt_q[f_bidx];
          predTaken    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- training ----------------
  logic [BTB_IDX-1:0]  u_bidx;
  logic [GHR_BITS-1:0] u_pidx;
  logic                u_cond, u_push, u_pop;

  assign u_bidx = PCUpdate[BTB_IDX+1:2];
  assign u_pidx = PCUpdate[GHR_BITS+1:2] ^ ghr_q;
  assign u_cond = we && (kindUpdate == KIND_COND);
  assign u_push = we && (kindUpdate == KIND_CALL);
  assign u_pop  = we && (kindUpdate == KIND_RETURN) && (ras_cnt_q != '0);

  always_comb begin
    ghr_d     = ghr_q;
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    if (u_cond) ghr_d = {ghr_q[GHR_BITS-2:0], takenUpdate};
    if (u_push) begin
      ras_ptr_d = ras_ptr_q + RAS_PW'(1);
      // full stack: the oldest slot is silently overwritten
      if (ras_cnt_q != CNT_W'(RAS_DEPTH)) ras_cnt_d = ras_cnt_q + CNT_W'(1);
    end else if (u_pop) begin
      ras_ptr_d = ras_top;
      ras_cnt_d = ras_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      ghr_q     <= '0;
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= CTR_INIT;
      for (int i = 0; i < BTB_N; i++) begin
        btb_vld_q[i]  <= 1'b0;
        btb_kind_q[i] <= KIND_COND;
      end
    end else begin
      ghr_q     <= ghr_d;
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
      if (u_cond) begin
        if (takenUpdate && pht_q[u_pidx] != 2'b11)
          pht_q[u_pidx] <= pht_q[u_pidx] + 2'b01;
        else if (!takenUpdate && pht_q[u_pidx] != 2'b00)
          pht_q[u_pidx] <= pht_q[u_pidx] - 2'b01;
      end
      if (we && takenUpdate) begin
        btb_vld_q[u_bidx]  <= 1'b1;
        btb_kind_q[u_bidx] <= kindUpdate;
      end
    end
  end

  // Payload arrays need no reset: they are only observed through valid/count.
  always_ff @(negedge clk) begin
    if (we && takenUpdate) begin
      btb_tag_q[u_bidx] <= PCUpdate[XLEN-1:BTB_IDX+2];
      btb_tgt_q[u_bidx] <= targetUpdate;
    end
    if (u_push) ras_q[ras_ptr_q] <= PCUpdate + XLEN'(4);
  end

endmodule

// File: tb/tb_branch_predictor_gshare_ras.sv
// Bench for branch_predictor_gshare_ras: behavioural reference model feeds an expectation queue,
// a monitor pops and compares each fetch's prediction.
module tb_branch_predictor_gshare_ras;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [XLEN-1:0] PC, PCPlus4, PCPrediction, PCUpdate, targetUpdate;
  logic            predTaken, we, takenUpdate;
  logic [1:0]      predKind, kindUpdate;

  int n_vec = 0;
  int n_err = 0;

  branch_predictor_gshare_ras dut (
    .clk(clk), .reset(reset), .PC(PC), .PCPlus4(PCPlus4), .PCPrediction(PCPrediction),
    .predTaken(predTaken), .predKind(predKind), .we(we), .PCUpdate(PCUpdate),
    .targetUpdate(targetUpdate), .takenUpdate(takenUpdate), .kindUpdate(kindUpdate)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [9:0]  m_ghr;
  int          m_pht [1024];
  logic        m_vld [256];
  logic [1:0]  m_kind[256];
  logic [53:0] m_tag [256];
  logic [63:0] m_tgt [256];
  logic [63:0] m_ras [$];

  function automatic void model_reset();
    m_ghr = '0;
    for (int i = 0; i < 1024; i++) m_pht[i] = 1;
    for (int i = 0; i < 256; i++) m_vld[i] = 1'b0;
    m_ras.delete();
  endfunction

  function automatic void model_train(input logic [63:0] pc, input logic [63:0] tgt,
                                      input logic tk, input logic [1:0] kd);
    int bi, pi;
    bi = int'(pc[9:2]);
    pi = int'(pc[11:2] ^ m_ghr);
    if (kd == 2'b00) begin
      if (tk && m_pht[pi] < 3) m_pht[pi]++;
      if (!tk && m_pht[pi] > 0) m_pht[pi]--;
      m_ghr = {m_ghr[8:0], tk};
    end
    if (tk) begin
      m_vld[bi] = 1'b1; m_kind[bi] = kd; m_tag[bi] = pc[63:10]; m_tgt[bi] = tgt;
    end
    if (kd == 2'b10) begin
      m_ras.push_back(pc + 64'd4);
      if (m_ras.size() > 8) void'(m_ras.pop_front());
    end
    if (kd == 2'b11 && m_ras.size() > 0) void'(m_ras.pop_back());
  endfunction

  typedef struct {
    string       name;
    logic [63:0] pc;
    logic [63:0] npc;
    logic        tk;
    logic [1:0]  kd;
  } exp_t;
  exp_t exp_q[$];
  event fetch_ev;

  // drive a fetch PC and queue what the model predicts for it
  task automatic fetch(input logic [63:0] pc, input string name);
    exp_t e;
    int bi;
    bi = int'(pc[9:2]);
    e.name = name; e.pc = pc; e.npc = pc + 64'd4; e.tk = 1'b0; e.kd = 2'b00;
    if (m_vld[bi] && m_tag[bi] == pc[63:10]) begin
      e.kd = m_kind[bi];
      case (m_kind[bi])
        2'b00: if (m_pht[int'(pc[11:2] ^ m_ghr)] >= 2) begin e.npc = m_tgt[bi]; e.tk = 1'b1; end
        2'b11: begin
          e.npc = (m_ras.size() > 0) ? m_ras[$] : m_tgt[bi];
          e.tk  = 1'b1;
        end
        default: begin e.npc = m_tgt[bi]; e.tk = 1'b1; end
      endcase
    end
    PC = pc;
    exp_q.push_back(e);
    -> fetch_ev;
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(fetch_ev);
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if (PCPlus4 !== e.pc + 64'd4) begin
        n_err++; $display("FAIL %s.plus4 got %h want %h", e.name, PCPlus4, e.pc + 64'd4);
      end
      n_vec++;
      if (PCPrediction !== e.npc) begin
        n_err++; $display("FAIL %s.pred got %h want %h", e.name, PCPrediction, e.npc);
      end
      n_vec++;
      if (predTaken !== e.tk || predKind !== e.kd) begin
        n_err++;
        $display("FAIL %s.taken_kind got %b/%b want %b/%b", e.name, predTaken, predKind, e.tk, e.kd);
      end
    end
  end

  task automatic train(input logic [63:0] pc, input logic [63:0] tgt,
                       input logic tk, input logic [1:0] kd);
    @(posedge clk); #1;
    we = 1'b1; PCUpdate = pc; targetUpdate = tgt; takenUpdate = tk; kindUpdate = kd;
    @(negedge clk);
    model_train(pc, tgt, tk, kd);
    #1 we = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; we = 1'b0; PC = '0; PCUpdate = '0; targetUpdate = '0;
    takenUpdate = 1'b0; kindUpdate = 2'b00;
    model_reset();
    #12 reset = 1'b0;
    fetch(64'h1000, "reset_fetch");
    n_vec++;
    if (PCPrediction !== 64'h1004) begin
      n_err++; $display("FAIL reset_const got %h want %h", PCPrediction, 64'h1004);
    end
  endtask

  task automatic test_gshare();
    for (int i = 0; i < 12; i++) train(64'h2000, 64'h2400, 1'b1, 2'b00);
    fetch(64'h2000, "gshare_taken");
    n_vec++;
    if (PCPrediction !== 64'h2400 || predTaken !== 1'b1) begin
      n_err++; $display("FAIL gshare_const got %h/%b want 2400/1", PCPrediction, predTaken);
    end
    train(64'h2000, 64'h2400, 1'b0, 2'b00);
    fetch(64'h2000, "gshare_nt1");
    train(64'h2000, 64'h2400, 1'b0, 2'b00);
    fetch(64'h2000, "gshare_nt2");
    n_vec++;
    if (PCPrediction !== 64'h2004 || predTaken !== 1'b0) begin
      n_err++; $display("FAIL gshare_nt_const got %h/%b want 2004/0", PCPrediction, predTaken);
    end
  endtask

  task automatic test_jump_alias();
    train(64'h3000, 64'h5000, 1'b1, 2'b01);
    fetch(64'h3000, "jump_hit");
    fetch(64'h3400, "jump_alias_miss");
    fetch(64'h2000, "jump_evicted_cond");
  endtask

  task automatic test_ras_basic();
    train(64'h4000, 64'h8000, 1'b1, 2'b10);
    fetch(64'h4000, "call_hit");
    fetch(64'h8010, "ret_untrained");
    train(64'h8010, 64'h4004, 1'b1, 2'b11);
    fetch(64'h8010, "ret_empty_fallback");
    train(64'h6000, 64'h8000, 1'b1, 2'b10);
    fetch(64'h8010, "ret_from_ras");
    n_vec++;
    if (PCPrediction !== 64'h6004) begin
      n_err++; $display("FAIL ras_const got %h want %h", PCPrediction, 64'h6004);
    end
  endtask

  task automatic test_ras_overflow();
    for (int k = 1; k <= 9; k++) train(64'h100 * k, 64'h8000, 1'b1, 2'b10);
    for (int k = 0; k < 8; k++) begin
      fetch(64'h8010, $sformatf("ret_pop%0d", k));
      n_vec++;
      if (PCPrediction !== 64'h904 - 64'h100 * k) begin
        n_err++; $display("FAIL ras_order%0d got %h want %h", k, PCPrediction, 64'h904 - 64'h100 * k);
      end
      train(64'h8010, 64'h4004, 1'b1, 2'b11);
    end
    fetch(64'h8010, "ret_underflow_fallback");
    train(64'h8010, 64'h4004, 1'b1, 2'b11);
    fetch(64'h8010, "ret_pop_empty_noop");
  endtask

  task automatic test_back_to_back();
    // same-edge update and fetch of one entry: fetch must see the pre-edge state
    @(posedge clk); #1;
    we = 1'b1; PCUpdate = 64'hA000; targetUpdate = 64'hB000; takenUpdate = 1'b1; kindUpdate = 2'b01;
    fetch(64'hA000, "same_edge_old");
    @(negedge clk);
    model_train(64'hA000, 64'hB000, 1'b1, 2'b01);
    #1 we = 1'b0;
    fetch(64'hA000, "same_edge_new");
    train(64'hC000, 64'hC100, 1'b0, 2'b00);
    train(64'hC000, 64'hC100, 1'b1, 2'b00);
    train(64'hC000, 64'hC100, 1'b1, 2'b00);
    fetch(64'hC000, "b2b_cond");
    train(64'hC004, 64'hD000, 1'b0, 2'b01);
    fetch(64'hC004, "nt_jump_no_alloc");
  endtask

  task automatic test_reset_midupdate();
    @(posedge clk); #1;
    we = 1'b1; PCUpdate = 64'h7000; targetUpdate = 64'h7100; takenUpdate = 1'b1; kindUpdate = 2'b10;
    #2 reset = 1'b1;
    model_reset();
    fetch(64'h8010, "rst_async_ret");
    n_vec++;
    if (predTaken !== 1'b0 || predKind !== 2'b00 || PCPrediction !== 64'h8014) begin
      n_err++; $display("FAIL rst_async_const got %h/%b/%b want 8014/0/00", PCPrediction, predTaken, predKind);
    end
    @(negedge clk); #1 we = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    fetch(64'h800, "rst_btb_miss0");
    fetch(64'hA000, "rst_btb_miss1");
    fetch(64'h7000, "rst_no_write");
    // GHR must restart from zero for the gshare index to match the model
    train(64'h2000, 64'h2400, 1'b1, 2'b00);
    train(64'h2000, 64'h2400, 1'b1, 2'b00);
    fetch(64'h2000, "rst_ghr_cond");
    train(64'h2000, 64'h2400, 1'b1, 2'b00);
    fetch(64'h2000, "rst_ghr_cond2");
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_gshare();
    test_jump_alias();
    test_ras_basic();
    test_ras_overflow();
    test_back_to_back();
    test_reset_midupdate();
    #5;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain got %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
